// File: rtl/xgriscv_dmem_ctrl_if.sv
// Request/response bundle between the xgriscv memory stage and the data memory controller.
interface xgriscv_dmem_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [XLEN/8-1:0] amp;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic              ack;
  logic              err;
  logic [XLEN-1:0]   rdata;
  logic              busy;
  logic              stall;

  modport master (
    output req, we, amp, addr, wdata,
    input  ack, err, rdata, busy, stall
  );

  modport slave (
    input  req, we, amp, addr, wdata,
    output ack, err, rdata, busy, stall
  );
endinterface

// File: rtl/xgriscv_dmem_ctrl.sv
// Wait-state data memory controller: one latched request, LATENCY wait cycles, then a one-cycle ack.
// Define DMEM_ERR_EN to enable alignment/range checking and the err response.
module xgriscv_dmem_ctrl #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  xgriscv_dmem_ctrl_if.slave bus
);
  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              we_reg;
  logic [NB-1:0]     amp_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic              ack_reg, err_reg;
  logic [XLEN-1:0]   rdata_reg;
  logic              do_access;
  logic              mem_we;
  logic              reject;
  logic [IW-1:0]     idx_raw, idx;
  logic [XLEN-1:0]   lane_mask;

  logic [XLEN-1:0]   mem [DEPTH];

  assign idx_raw = addr_reg[LB +: IW];

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane_mask
    assign lane_mask[gi*8 +: 8] = {8{amp_reg[gi]}};
  end

`ifdef DMEM_ERR_EN
  int   amp_lo, amp_hi, amp_pop;
  logic amp_found;
  logic amp_ok, range_bad;

  always_comb begin
    amp_lo    = 0;
    amp_hi    = 0;
    amp_pop   = 0;
    amp_found = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (amp_reg[i]) begin
        amp_pop = amp_pop + 1;
        amp_hi  = i;
        if (!amp_found) begin
          amp_lo    = i;
          amp_found = 1'b1;
        end
      end
    end
  end

  // Contiguous + power-of-two size + naturally aligned to the byte offset in addr.
  assign amp_ok = amp_found
               && (amp_hi - amp_lo + 1 == amp_pop)
               && ((amp_pop & (amp_pop - 1)) == 0)
               && (amp_lo == int'(addr_reg[LB-1:0]))
               && ((amp_lo & (amp_pop - 1)) == 0);
  assign range_bad = ((addr_reg >> (LB + IW)) != '0) || (32'(idx_raw) >= 32'(DEPTH));
  assign reject    = !amp_ok || range_bad;
  assign idx       = idx_raw;
`else
  logic addr_unused;

  assign addr_unused = ^addr_reg;
  assign reject      = 1'b0;
  // Single subtraction suffices: idx_raw < 2*DEPTH because IW = clog2(DEPTH).
  assign idx = (32'(idx_raw) >= 32'(DEPTH)) ? IW'(idx_raw - IW'(DEPTH)) : idx_raw;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    do_access  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req) begin
          state_next = WAIT;
          cnt_next   = 4'(LATENCY);
        end
      end
      WAIT: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          do_access  = 1'b1;
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      amp_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= do_access;
      err_reg   <= do_access & reject;
      if (state_reg == IDLE && bus.req) begin
        we_reg    <= bus.we;
        amp_reg   <= bus.amp;
        addr_reg  <= bus.addr;
        wdata_reg <= bus.wdata;
      end
      if (do_access) begin
        if (reject) begin
          rdata_reg <= '0;
        end else if (!we_reg) begin
          rdata_reg <= mem[idx] & lane_mask;
        end
      end
    end
  end

  // Reset drops the FSM out of WAIT asynchronously, so a pending store never reaches mem_we.
  assign mem_we = do_access & we_reg & ~reject;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (amp_reg[i]) mem[idx][i*8 +: 8] <= wdata_reg[i*8 +: 8];
      end
    end
  end

  assign bus.ack   = ack_reg;
  assign bus.err   = err_reg;
  assign bus.rdata = rdata_reg;
  assign bus.busy  = (state_reg != IDLE);
  assign bus.stall = bus.req & ~ack_reg;
endmodule

// File: tb/tb_xgriscv_dmem_ctrl.sv
// Randomized self-checking bench for xgriscv_dmem_ctrl against a word-array reference model.
module tb_xgriscv_dmem_ctrl;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;
  localparam int NB    = 4;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;
  logic [31:0] mdl [DEPTH];

  xgriscv_dmem_ctrl_if #(.XLEN(32), .ADDR_W(32)) bif ();

  xgriscv_dmem_ctrl #(
    .XLEN(32), .DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: expected err/rdata from the access rules, updating the model array on stores.
  task automatic model_access(input logic we, input logic [3:0] amp, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic exp_err, output logic [31:0] exp_rd);
    logic [31:0] mask;
    int idx, p, lo;
    mask = 0;
    for (int i = 0; i < NB; i++) if (amp[i]) mask[i*8 +: 8] = 8'hFF;
    exp_err = 1'b0;
    exp_rd  = 0;
`ifdef DMEM_ERR_EN
    p  = $countones(amp);
    lo = 0;
    while (lo < NB && !amp[lo]) lo++;
    if (!(p == 1 || p == 2 || p == 4) || (32'(amp) != (((32'd1 << p) - 1) << lo))
        || (lo != int'(addr % NB)) || (lo % p != 0) || ((addr / NB) >= DEPTH)) begin
      exp_err = 1'b1;
      return;
    end
    idx = int'(addr / NB);
`else
    p = 0; lo = 0;
    idx = int'((addr / NB) % DEPTH);
`endif
    if (we) mdl[idx] = (mdl[idx] & ~mask) | (wdata & mask);
    else    exp_rd = mdl[idx] & mask;
  endtask

  // Drives one request starting at a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic dut_access(input logic we, input logic [3:0] amp, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic err, output logic [31:0] rd,
                            output int lat);
    bif.req = 1'b1; bif.we = we; bif.amp = amp; bif.addr = addr; bif.wdata = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      // Scramble the request fields to show the latched copies are used.
      bif.we = ~we; bif.amp = 4'($urandom); bif.addr = $urandom; bif.wdata = $urandom;
      if (!bif.ack) check("stall_wait", 64'(bif.stall), 64'd1);
    end while (!bif.ack && lat < 50);
    if (!bif.ack) check("ack_timeout", 64'(bif.ack), 64'd1);
    err = bif.err;
    rd  = bif.rdata;
    check("stall_ack", 64'(bif.stall), 64'd0);
    bif.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_txn(input string tag, input logic we, input logic [3:0] amp,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic err);
    logic exp_err;
    logic [31:0] exp_rd;
    int lat;
    model_access(we, amp, addr, wdata, exp_err, exp_rd);
    dut_access(we, amp, addr, wdata, err, rd, lat);
    $display("txn %s we=%0d amp=%b addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
             tag, we, amp, addr, wdata, rd, err, lat);
    check({tag, "_lat"}, 64'(lat), 64'(LAT + 2));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    if (!we || exp_err) check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
  endtask

  initial begin
    logic [31:0] rd;
    logic err;
    logic [3:0] amp;
    logic [31:0] addr;
    int p, lane, acks, first_ack, second_ack;

    n_total = 0;
    n_bad   = 0;
    reset   = 1'b0;
    bif.req = 1'b0; bif.we = 1'b0; bif.amp = '0; bif.addr = '0; bif.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(bif.ack), 64'd0);
    check("rst_err", 64'(bif.err), 64'd0);
    check("rst_rdata", 64'(bif.rdata), 64'd0);
    check("rst_busy", 64'(bif.busy), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) do_txn("init", 1'b1, 4'hF, 32'(i * NB), $urandom, rd, err);

    do_txn("st_word", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, err);
    do_txn("ld_word", 1'b0, 4'hF, 32'h10, 32'h0, rd, err);
    check("ld_word_const", 64'(rd), 64'hDEADBEEF);
    do_txn("st_byte", 1'b1, 4'b0010, 32'h11, 32'h0000AA00, rd, err);
    do_txn("ld_word2", 1'b0, 4'hF, 32'h10, 32'h0, rd, err);
    check("ld_word2_const", 64'(rd), 64'hDEADAAEF);
    do_txn("ld_half", 1'b0, 4'b1100, 32'h12, 32'h0, rd, err);
    check("ld_half_const", 64'(rd), 64'hDEAD0000);
`ifdef DMEM_ERR_EN
    do_txn("st_misal", 1'b1, 4'b1100, 32'h13, 32'h12345678, rd, err);
    check("st_misal_const", 64'(err), 64'd1);
    do_txn("ld_after_misal", 1'b0, 4'hF, 32'h10, 32'h0, rd, err);
    check("ld_after_misal_const", 64'(rd), 64'hDEADAAEF);
    do_txn("ld_range", 1'b0, 4'hF, 32'(4 * DEPTH), 32'h0, rd, err);
    check("ld_range_err_const", 64'(err), 64'd1);
`endif

    // req held across two accesses: acks spaced by the full IDLE-WAIT-ACK round trip.
    bif.req = 1'b1; bif.we = 1'b0; bif.amp = 4'hF; bif.addr = 32'h10; bif.wdata = '0;
    acks = 0; first_ack = 0; second_ack = 0;
    for (int n = 1; n <= 2 * LAT + 6; n++) begin
      @(negedge clk);
      check("held_stall", 64'(bif.stall), 64'(!bif.ack));
      if (bif.ack) begin
        acks++;
        if (acks == 1) first_ack = n; else second_ack = n;
        check("held_rdata", 64'(bif.rdata), 64'(mdl[4]));
      end
    end
    bif.req = 1'b0;
    $display("txn held acks=%0d first=%0d second=%0d", acks, first_ack, second_ack);
    check("held_acks", 64'(acks), 64'd2);
    check("held_first", 64'(first_ack), 64'(LAT + 2));
    check("held_gap", 64'(second_ack - first_ack), 64'(LAT + 3));

    // Store interrupted by reset while waiting.
    bif.req = 1'b1; bif.we = 1'b1; bif.amp = 4'hF; bif.addr = 32'h10; bif.wdata = 32'h12345678;
    repeat (2) @(negedge clk);
    check("rst_wait_busy_pre", 64'(bif.busy), 64'd1);
    reset = 1'b0;
    #1;
    check("rst_wait_busy", 64'(bif.busy), 64'd0);
    bif.req = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("rst_hold_ack", 64'(bif.ack), 64'd0);
    end
    reset = 1'b1;
    for (int n = 0; n < LAT + 4; n++) begin
      @(negedge clk);
      check("rst_after_ack", 64'(bif.ack), 64'd0);
    end
    $display("txn reset_in_wait addr=00000010");
    do_txn("ld_after_rst", 1'b0, 4'hF, 32'h10, 32'h0, rd, err);
    check("ld_after_rst_const", 64'(rd), 64'hDEADAAEF);

    // Random mix of aligned and (occasionally) irregular accesses.
    for (int t = 0; t < 150; t++) begin
      p    = 1 << $urandom_range(0, 2);
      lane = p * $urandom_range(0, NB / p - 1);
      amp  = 4'(((1 << p) - 1) << lane);
      addr = 32'($urandom_range(0, DEPTH - 1) * NB + lane);
      if ($urandom_range(0, 9) == 0) amp = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      do_txn("rand", 1'($urandom), amp, addr, $urandom, rd, err);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
